sync_coupled_oscillator: RTL and testbench
==========================================

SYNC_COUPLED_OSCILLATOR -- requirements
Module: sync_coupled_oscillator

Interface
REQ-001 Parameter N, default 3, number of coupling inputs.
REQ-002 Parameter W, default 3, width of each coupling weight, two's complement.
REQ-003 Parameter ACC_W, default 8, phase accumulator width.
REQ-004 Parameter BASE_STEP, default 16, uncoupled phase increment per enabled cycle, range 1..2^ACC_W-1.
REQ-005 Parameter CYC_W, default 16, width of the half-period measurement.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  advances the phase when high; state holds when low.
REQ-009 load  input  1  synchronous spin preset strobe.
REQ-010 load_val  input  1  spin value applied on load.
REQ-011 coupling_inputs  input  N  neighbour spins; bit i is neighbour i.
REQ-012 coupling_weights  input  N*W  weight J_i at bits [i*W +: W], signed.
REQ-013 out  output  1  registered spin/oscillator output.
REQ-014 toggle  output  1  one-cycle pulse, high in the cycle after out changes due to phase overflow.
REQ-015 half_period  output  CYC_W  enabled-cycle count of the last completed half period.
REQ-016 period_valid  output  1  high once half_period holds a measurement since reset/load.

Function
REQ-017 Per cycle, s_i SHALL be +1 if coupling_inputs[i] != out, else -1.
REQ-018 The raw step SHALL be BASE_STEP + sum(s_i*J_i), computed signed and wide enough to never overflow (at least W+clog2(N)+ACC_W+2 bits).
REQ-019 The applied step SHALL be the raw step clamped to [1, 2^ACC_W-1].
REQ-020 When en=1 and load=0, phase+step SHALL be computed ACC_W+1 bits wide; phase takes the low ACC_W bits, and a carry out SHALL invert out on the same edge.
REQ-021 Only one toggle per cycle SHALL occur; the remainder after wrap SHALL be kept in phase (no phase loss).
REQ-022 An internal counter cyc (CYC_W bits) SHALL increment every enabled non-toggling cycle, saturating at 2^CYC_W-1.
REQ-023 On a toggling cycle half_period SHALL load min(cyc+1, 2^CYC_W-1), cyc SHALL clear, period_valid SHALL set, and toggle SHALL be high on the next cycle only.
REQ-024 When en=0 and load=0, out, phase, cyc, half_period and period_valid SHALL hold; toggle SHALL be 0.
REQ-025 load=1 SHALL have priority over en: out<=load_val, phase<=0, cyc<=0, period_valid<=0, toggle<=0, half_period holds.
REQ-026 Coupling inputs and weights SHALL be sampled combinationally against the current registered out; no extra latency.
REQ-027 Changing weights mid-half-period SHALL affect only subsequent steps.

Reset
REQ-028 While rst=1, out=0, phase=0, cyc=0, half_period=0, period_valid=0, toggle=0, independent of clk.
REQ-029 Deassertion of rst SHALL resume counting from phase 0 on the first enabled edge; reset mid-half-period discards that partial measurement.

Verification
REQ-030 Defaults, all weights 0, en=1 from reset -> out toggles every 16 cycles; first toggle pulse after 16th edge, half_period=16, period_valid=1.
REQ-031 N=3,W=3, weights 010 each, coupling_inputs=111, en=1 from reset -> step 22 while out=0: first half_period=12 (phase remainder 8); step 10 while out=1: second half_period=25.
REQ-032 BASE_STEP=4, weights 100 each, coupling_inputs=111, out=0 -> raw step -8 clamped to 1; first half_period=256.
REQ-033 Mid-half-period en=0 for 10 cycles -> out, phase, cyc frozen, toggle=0; measured half_period excludes the 10 disabled cycles (still 16 with zero weights).
REQ-034 load=1 with load_val=1 and en=1 in same cycle -> out=1, phase=0, period_valid=0 next cycle; next toggle 16 cycles after load.
REQ-035 rst asserted asynchronously mid-half-period (between edges) -> all outputs to reset values immediately; after release, first half_period=16.

Source files
------------

// File: rtl/sync_coupled_oscillator.sv
// -----------------------------------------------------------------------------
// sync_coupled_oscillator
//
// Phase-accumulator oscillator with spin-style coupling. Each enabled cycle the
// phase advances by BASE_STEP plus a coupling term sum(s_i * J_i). The term
// s_i is +1 when neighbour i disagrees with the current output and -1 when it
// agrees. The applied step is clamped to [1, 2^ACC_W-1]. A carry out of the
// accumulator flips the output, and the remainder stays in the phase. The
// module also measures the length of each half period in enabled cycles.
//
// Parameters:
//   N          number of coupling inputs
//   W          width of each signed coupling weight
//   ACC_W      phase accumulator width
//   BASE_STEP  uncoupled phase increment (1 .. 2^ACC_W-1)
//   CYC_W      width of the half-period measurement
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   en                advance the phase this cycle
//   load              synchronous spin preset (has priority over en)
//   load_val          spin value applied on load
//   coupling_inputs   neighbour spins, bit i = neighbour i
//   coupling_weights  J_i at bits [i*W +: W], two's complement
//   out               registered spin / oscillator output
//   toggle            one-cycle pulse in the cycle after an overflow flip
//   half_period       enabled-cycle length of the last completed half period
//   period_valid      half_period holds a measurement since reset/load
// -----------------------------------------------------------------------------
module sync_coupled_oscillator #(
   parameter int N         = 3,
   parameter int W         = 3,
   parameter int ACC_W     = 8,
   parameter int BASE_STEP = 16,
   parameter int CYC_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load,
   input  logic                 load_val,
   input  logic [N-1:0]         coupling_inputs,
   input  logic [N*W-1:0]       coupling_weights,
   output logic                 out,
   output logic                 toggle,
   output logic [CYC_W-1:0]     half_period,
   output logic                 period_valid
);

   // The sum is wide enough for BASE_STEP plus N worst-case weight magnitudes.
   // The clamp below therefore always sees the true signed value.
   localparam int SUM_W = W + $clog2(N + 1) + ACC_W + 3;

   localparam logic signed [SUM_W-1:0] BASE_S   = SUM_W'(BASE_STEP);
   localparam logic signed [SUM_W-1:0] STEP_MIN = SUM_W'(1);
   localparam logic signed [SUM_W-1:0] STEP_MAX = SUM_W'((1 << ACC_W) - 1);

   logic                  out_reg;
   logic                  toggle_reg;
   logic [ACC_W-1:0]      phase_reg;
   logic [CYC_W-1:0]      cyc_reg;
   logic [CYC_W-1:0]      half_period_reg;
   logic                  period_valid_reg;

   logic signed [SUM_W-1:0] term [N];
   logic signed [SUM_W-1:0] raw_step;
   logic [ACC_W-1:0]        step;
   logic [ACC_W:0]          phase_sum;
   logic                    carry;
   logic [CYC_W-1:0]        cyc_sat_inc;

   // Each term is +J_i when neighbour i disagrees with out, and -J_i otherwise.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_term
         logic [W-1:0]            j_raw;
         logic signed [SUM_W-1:0] j_ext;
         assign j_raw    = coupling_weights[gi*W +: W];
         assign j_ext    = {{(SUM_W - W){j_raw[W-1]}}, j_raw};
         assign term[gi] = (coupling_inputs[gi] != out_reg) ? j_ext : -j_ext;
      end
   endgenerate

   always_comb begin
      raw_step = BASE_S;
      for (int i = 0; i < N; i++) begin
         raw_step = raw_step + term[i];
      end
   end

   // Clamp the step to [1, 2^ACC_W-1]. With this range the phase always
   // moves forward, and it wraps at most once per cycle.
   always_comb begin
      if (raw_step < STEP_MIN) begin
         step = {{(ACC_W-1){1'b0}}, 1'b1};
      end else if (raw_step > STEP_MAX) begin
         step = '1;
      end else begin
         step = raw_step[ACC_W-1:0];
      end
   end

   assign phase_sum = {1'b0, phase_reg} + {1'b0, step};
   assign carry     = phase_sum[ACC_W];

   // Saturating increment. It also gives min(cyc+1, max) for the half-period
   // capture.
   assign cyc_sat_inc = (cyc_reg == '1) ? cyc_reg : cyc_reg + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg          <= 1'b0;
         toggle_reg       <= 1'b0;
         phase_reg        <= '0;
         cyc_reg          <= '0;
         half_period_reg  <= '0;
         period_valid_reg <= 1'b0;
      end else if (load) begin
         out_reg          <= load_val;
         toggle_reg       <= 1'b0;
         phase_reg        <= '0;
         cyc_reg          <= '0;
         period_valid_reg <= 1'b0;
      end else if (en) begin
         // Keep the low bits after a wrap so that no phase is lost.
         phase_reg  <= phase_sum[ACC_W-1:0];
         toggle_reg <= carry;
         if (carry) begin
            out_reg          <= ~out_reg;
            half_period_reg  <= cyc_sat_inc;
            cyc_reg          <= '0;
            period_valid_reg <= 1'b1;
         end else begin
            cyc_reg <= cyc_sat_inc;
         end
      end else begin
         toggle_reg <= 1'b0;
      end
   end

   assign out          = out_reg;
   assign toggle       = toggle_reg;
   assign half_period  = half_period_reg;
   assign period_valid = period_valid_reg;

endmodule

// File: tb/tb_sync_coupled_oscillator.sv
// -----------------------------------------------------------------------------
// tb_sync_coupled_oscillator
//
// Self-checking bench. The main instance runs a table of half-period
// scenarios. Each expected length is computed by hand from the step and phase
// arithmetic. Hand-written sequences cover enable gating, load priority and
// asynchronous reset. Two extra instances cover the low clamp (BASE_STEP=4)
// and half_period saturation (CYC_W=4).
// -----------------------------------------------------------------------------
module tb_sync_coupled_oscillator;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic        load_val;
   logic [2:0]  ci;
   logic [8:0]  cw;
   logic        out;
   logic        toggle;
   logic [15:0] hp;
   logic        pv;

   // Low-clamp instance (BASE_STEP=4) and saturation instance (CYC_W=4).
   logic        rst_b;
   logic        en_b;
   logic        load_b;
   logic [2:0]  ci_b;
   logic [8:0]  cw_b;
   logic [8:0]  cw_c;
   logic        out_b;
   logic        tog_b;
   logic [15:0] hp_b;
   logic        pv_b;
   logic        out_c;
   logic        tog_c;
   logic [3:0]  hp_c;
   logic        pv_c;

   int checks = 0;
   int errors = 0;

   sync_coupled_oscillator dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .coupling_inputs(ci), .coupling_weights(cw),
      .out(out), .toggle(toggle), .half_period(hp), .period_valid(pv)
   );

   sync_coupled_oscillator #(.BASE_STEP(4)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .load(load_b), .load_val(1'b0),
      .coupling_inputs(ci_b), .coupling_weights(cw_b),
      .out(out_b), .toggle(tog_b), .half_period(hp_b), .period_valid(pv_b)
   );

   sync_coupled_oscillator #(.BASE_STEP(1), .CYC_W(4)) dut_c (
      .clk(clk), .rst(rst_b), .en(en_b), .load(load_b), .load_val(1'b0),
      .coupling_inputs(ci_b), .coupling_weights(cw_c),
      .out(out_c), .toggle(tog_c), .half_period(hp_c), .period_valid(pv_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         do_rst;
      logic [2:0] ci;
      logic [8:0] cw;
      int         exp_hp;
      logic       exp_out;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Counts edges until toggle is seen. Returns -1 if the bound expires.
   task automatic wait_toggle(output int n);
      bit done;
      done = 1'b0;
      n = 0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (toggle) done = 1'b1;
      end
      if (!done) n = -1;
   endtask

   initial begin
      int n;
      int nb, nc, hpb, hpc;

      rst = 1'b1; en = 1'b1; load = 1'b0; load_val = 1'b0;
      ci = '0; cw = '0;
      rst_b = 1'b1; en_b = 1'b1; load_b = 1'b0;
      ci_b = 3'b111; cw_b = 9'b100_100_100; cw_c = '0;

      // Expected lengths. For weights +2 with all neighbours disagreeing, the
      // step is 22 while out is 0 and 10 while out is 1. For weights -4 it is
      // 4 or 28. The mixed row gives step 16+1+1+3=21 from phase 24.
      vecs[0] = '{1'b1, 3'b000, 9'b000_000_000, 16, 1'b1};
      vecs[1] = '{1'b0, 3'b000, 9'b000_000_000, 16, 1'b0};
      vecs[2] = '{1'b1, 3'b111, 9'b010_010_010, 12, 1'b1}; // phase 8 left
      vecs[3] = '{1'b0, 3'b111, 9'b010_010_010, 25, 1'b0}; // phase 2 left
      vecs[4] = '{1'b0, 3'b111, 9'b010_010_010, 12, 1'b1}; // phase 10 left
      vecs[5] = '{1'b0, 3'b000, 9'b010_010_010, 12, 1'b0}; // phase 18 left
      vecs[6] = '{1'b1, 3'b111, 9'b100_100_100, 64, 1'b1}; // phase 0 left
      vecs[7] = '{1'b0, 3'b111, 9'b100_100_100, 10, 1'b0}; // phase 24 left
      vecs[8] = '{1'b0, 3'b101, 9'b011_111_001, 12, 1'b1};

      // Reset is asynchronous, so outputs are defined before any clock edge.
      #3;
      chk("reset_out", int'(out), 0);
      chk("reset_toggle", int'(toggle), 0);
      chk("reset_hp", int'(hp), 0);
      chk("reset_pv", int'(pv), 0);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_rst) do_reset();
         ci = vecs[i].ci;
         cw = vecs[i].cw;
         wait_toggle(n);
         chk($sformatf("vec%0d_edges", i), n, vecs[i].exp_hp);
         chk($sformatf("vec%0d_hp", i), int'(hp), vecs[i].exp_hp);
         chk($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
         chk($sformatf("vec%0d_pv", i), int'(pv), 1);
         $display("vec %0d: edges=%0d hp=%0d out=%0b pv=%0b", i, n, hp, out, pv);
      end

      // Enable gating: 10 disabled cycles are excluded from the measurement.
      ci = '0; cw = '0;
      do_reset();
      repeat (5) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("gate_out", int'(out), 0);
      chk("gate_toggle", int'(toggle), 0);
      chk("gate_pv", int'(pv), 0);
      en = 1'b1;
      wait_toggle(n);
      chk("gate_edges", n, 11);
      chk("gate_hp", int'(hp), 16);
      $display("gate: edges=%0d hp=%0d", n, hp);

      // Bring out back to 0, then load 1 while enabled. Load must win.
      wait_toggle(n);
      chk("pre_load_out", int'(out), 0);
      repeat (5) @(negedge clk);
      load = 1'b1; load_val = 1'b1;
      @(negedge clk);
      load = 1'b0; load_val = 1'b0;
      chk("load_out", int'(out), 1);
      chk("load_pv", int'(pv), 0);
      chk("load_toggle", int'(toggle), 0);
      chk("load_hp_hold", int'(hp), 16);
      wait_toggle(n);
      chk("load_edges", n, 16);
      chk("load_next_out", int'(out), 0);
      $display("load: edges=%0d out=%0b", n, out);

      // Asynchronous reset between edges, mid-half-period.
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("areset_out", int'(out), 0);
      chk("areset_hp", int'(hp), 0);
      chk("areset_pv", int'(pv), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_toggle(n);
      chk("areset_edges", n, 16);
      chk("areset_hp_after", int'(hp), 16);
      @(negedge clk);
      chk("toggle_one_cycle", int'(toggle), 0);
      chk("pv_holds", int'(pv), 1);
      $display("areset: edges=%0d hp=%0d", n, hp);

      // Clamp instance: raw step 4-12=-8 is clamped to 1, so 256 cycles.
      // Saturation instance: 256 cycles are captured as 15.
      @(negedge clk);
      rst_b = 1'b0;
      nb = -1; nc = -1; hpb = -1; hpc = -1;
      for (int k = 1; k <= 600 && (nb < 0 || nc < 0); k++) begin
         @(posedge clk);
         @(negedge clk);
         if (tog_b && nb < 0) begin nb = k; hpb = int'(hp_b); end
         if (tog_c && nc < 0) begin nc = k; hpc = int'(hp_c); end
      end
      chk("clamp_edges", nb, 256);
      chk("clamp_hp", hpb, 256);
      chk("clamp_out", int'(out_b), 1);
      chk("sat_edges", nc, 256);
      chk("sat_hp", hpc, 15);
      $display("clamp: edges=%0d hp=%0d sat: edges=%0d hp=%0d", nb, hpb, nc, hpc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
